// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port memory between the instruction-fetch and data ports
// of the core. All three sides use the req/gnt/rvalid handshake. Up to two
// accesses may be outstanding at the memory; a 2-entry owner FIFO remembers
// who issued each one so responses are routed back in order.
//
// Data has fixed priority over fetch. Defining MEM_ARB_STARVE_GUARD_EN adds a
// wait counter so that a fetch that has lost WAIT_MAX cycles in a row wins the
// next arbitration.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   instr_req_i/gnt_o/rvalid_o   fetch handshake
//   instr_addr_i, instr_rdata_o  fetch address / returned data
//   data_req_i/gnt_o/rvalid_o    load/store handshake
//   data_addr_i, data_we_i, data_be_i, data_wdata_i, data_rdata_o
//   mem_req_o/gnt_i/rvalid_i     memory handshake
//   mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_rdata_i
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_MAX   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,

  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,

  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  // Owner FIFO: bit value 0 = instr, 1 = data.
  logic [1:0] owner_q;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_cnt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       has_space;
  logic       head_data;

  logic       sel_lock;
  logic       lock_data;
  logic       sel_data;
  logic       xfer;

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign pop        = mem_rvalid_i && !fifo_empty;
  // A response arriving this cycle frees a slot for a same-cycle grant.
  assign has_space  = !fifo_full || mem_rvalid_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_MAX_C = WCW'(WAIT_MAX);

  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (!instr_req_i || instr_gnt_o) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX_C) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_wait_max = WAIT_MAX;
`endif

  always_comb begin
    sel_data = data_req_i;
    if (sel_lock) begin
      // A stalled request keeps the memory-side attributes frozen until granted.
      sel_data = lock_data;
    end else begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (instr_req_i && (wait_cnt == WAIT_MAX_C)) begin
        sel_data = 1'b0;
      end
`endif
    end
  end

  assign mem_req_o   = (instr_req_i || data_req_i) && has_space && !rst_i;
  assign xfer        = mem_req_o && mem_gnt_i;
  assign push        = xfer;

  assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
  assign mem_we_o    = sel_data && data_we_i;
  assign mem_be_o    = sel_data ? data_be_i : '1;
  assign mem_wdata_o = sel_data ? data_wdata_i : '0;

  assign instr_gnt_o = xfer && !sel_data;
  assign data_gnt_o  = xfer && sel_data;

  assign head_data      = owner_q[rd_ptr];
  assign instr_rvalid_o = pop && !head_data;
  assign data_rvalid_o  = pop && head_data;
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_lock  <= 1'b0;
      lock_data <= 1'b0;
    end else if (xfer) begin
      sel_lock  <= 1'b0;
    end else if (mem_req_o) begin
      sel_lock  <= 1'b1;
      lock_data <= sel_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A response with nothing outstanding is dropped; flag it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(mem_rvalid_i && fifo_empty))
        else $warning("mem_port_arbiter: mem_rvalid_i with no outstanding access, response dropped");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int WM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req, instr_gnt, instr_rvalid;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_rdata;
  logic          data_req, data_gnt, data_rvalid, data_we;
  logic [AW-1:0] data_addr;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_gnt, mem_rvalid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_MAX(WM)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_addr_i(data_addr), .data_we_i(data_we), .data_be_i(data_be),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    instr_req = 0; instr_addr = '0;
    data_req = 0; data_addr = '0; data_we = 0; data_be = '0; data_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // reference model state for the random phase
  bit            ip, dp, dwe, g, rv, space, mreq, w, eig, edg, o, lk, lkw;
  logic [AW-1:0] ia, da;
  logic [BW-1:0] dbe;
  logic [DW-1:0] dwd, rd;
  bit            oq[$];
  int            wcnt;
  bit            exp_i;

  initial begin
    idle();
    rst = 1;
    @(negedge clk); #1;
    chk("reset_out", {instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_req, instr_rdata, data_rdata}, '0);
    @(negedge clk); rst = 0;

    // single fetch
    @(negedge clk); idle(); instr_req = 1; instr_addr = 22'h80; mem_gnt = 1; #1;
    chk("fetch_gnt", {instr_gnt, data_gnt, mem_req}, 3'b101);
    chk("fetch_attr", {mem_addr, mem_we, mem_be, mem_wdata}, {22'h80, 1'b0, 4'hF, 32'h0});
    @(negedge clk); idle(); mem_rvalid = 1; mem_rdata = 32'h13; #1;
    chk("fetch_rsp", {instr_rvalid, instr_rdata, data_rvalid, data_rdata}, {1'b1, 32'h13, 1'b0, 32'h0});

    // simultaneous requests, data first
    @(negedge clk); idle(); instr_req = 1; instr_addr = 22'h100;
    data_req = 1; data_addr = 22'h2000; data_we = 1; data_be = 4'hF; data_wdata = 32'hDEADBEEF; mem_gnt = 1; #1;
    chk("both_gnt1", {instr_gnt, data_gnt}, 2'b01);
    chk("both_attr1", {mem_addr, mem_we, mem_be, mem_wdata}, {22'h2000, 1'b1, 4'hF, 32'hDEADBEEF});
    @(negedge clk); data_req = 0; mem_rvalid = 1; mem_rdata = 32'h55; #1;
    chk("both_gnt2", {instr_gnt, data_gnt, mem_addr}, {2'b10, 22'h100});
    chk("both_rsp1", {instr_rvalid, data_rvalid, data_rdata}, {2'b01, 32'h55});
    @(negedge clk); instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234; #1;
    chk("both_rsp2", {instr_rvalid, instr_rdata, data_rvalid}, {1'b1, 32'h1234, 1'b0});

    // stall with data arriving mid-stall
    @(negedge clk); idle(); instr_req = 1; instr_addr = 22'h300; #1;
    chk("stall_1", {mem_req, instr_gnt, mem_addr}, {2'b10, 22'h300});
    @(negedge clk); data_req = 1; data_addr = 22'h400; #1;
    chk("stall_2", {mem_req, data_gnt, instr_gnt, mem_addr}, {3'b100, 22'h300});
    @(negedge clk); #1;
    chk("stall_3", {mem_req, data_gnt, instr_gnt, mem_addr}, {3'b100, 22'h300});
    @(negedge clk); mem_gnt = 1; #1;
    chk("stall_gnt", {instr_gnt, data_gnt, mem_addr}, {2'b10, 22'h300});
    @(negedge clk); instr_req = 0; #1;
    chk("stall_data", {instr_gnt, data_gnt, mem_addr}, {2'b01, 22'h400});

    // FIFO full, then pop+push in one cycle
    @(negedge clk); data_req = 0; instr_req = 1; instr_addr = 22'h500; #1;
    chk("full_block", {mem_req, instr_gnt}, 2'b00);
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h77; #1;
    chk("full_popush", {mem_req, instr_gnt, instr_rvalid, instr_rdata}, {3'b111, 32'h77});
    @(negedge clk); instr_req = 0; mem_rdata = 32'h88; #1;
    chk("full_rsp2", {instr_rvalid, instr_rdata, data_rvalid, data_rdata}, {1'b0, 32'h0, 1'b1, 32'h88});
    @(negedge clk); mem_rdata = 32'h99; #1;
    chk("full_rsp3", {instr_rvalid, instr_rdata, data_rvalid}, {1'b1, 32'h99, 1'b0});

    // starvation
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); idle();
      instr_req = 1; instr_addr = 22'h600;
      data_req = 1; data_addr = AW'(32'h1000 + k * 4);
      mem_gnt = 1; mem_rvalid = (k > 1); mem_rdata = DW'(k);
      #1;
      exp_i = GUARD && (k == 5);
      chk($sformatf("starve_c%0d", k), {instr_gnt, data_gnt}, {exp_i, !exp_i});
    end
    @(negedge clk); idle(); mem_rvalid = 1; #1;
    @(negedge clk); idle(); #1;

    // reset with two accesses outstanding
    @(negedge clk); data_req = 1; data_addr = 22'h700; mem_gnt = 1; #1;
    chk("rst_pre1", data_gnt, 1'b1);
    @(negedge clk); data_addr = 22'h704; #1;
    chk("rst_pre2", data_gnt, 1'b1);
    @(negedge clk); idle(); rst = 1; instr_req = 1; mem_gnt = 1; mem_rvalid = 1; #1;
    chk("rst_mid", {instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_req, instr_rdata, data_rdata}, '0);
    @(negedge clk); rst = 0; idle(); mem_rvalid = 1; mem_rdata = 32'hAAAA; #1;
    chk("rst_drop", {instr_rvalid, data_rvalid, instr_rdata, data_rdata}, '0);
    @(negedge clk); idle(); #1;

    // random traffic against the reference model
    ip = 0; dp = 0; lk = 0; lkw = 0; wcnt = 0; oq.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!ip) begin
        ip = ($urandom_range(0, 1) == 1);
        ia = AW'($urandom & 32'hFFFF_FFFC);
      end
      if (!dp) begin
        dp  = ($urandom_range(0, 2) == 0);
        da  = AW'($urandom & 32'hFFFF_FFFC);
        dwe = ($urandom_range(0, 1) == 1);
        dbe = BW'($urandom_range(1, 15));
        dwd = $urandom;
      end
      g  = ($urandom_range(0, 3) != 0);
      rv = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
      rd = $urandom;
      instr_req = ip; instr_addr = ia;
      data_req = dp; data_addr = da; data_we = dwe; data_be = dbe; data_wdata = dwd;
      mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
      #1;
      space = (oq.size() < 2) || rv;
      mreq  = (ip || dp) && space;
      if (lk)                             w = lkw;
      else if (GUARD && ip && wcnt == WM) w = 1'b0;
      else                                w = dp;
      eig = mreq && g && !w;
      edg = mreq && g && w;
      chk("rnd_gnt", {instr_gnt, data_gnt, mem_req}, {eig, edg, mreq});
      if (mreq)
        chk("rnd_attr", {mem_addr, mem_we, mem_be, mem_wdata},
            w ? {da, dwe, dbe, dwd} : {ia, 1'b0, 4'hF, 32'h0});
      if (rv) begin
        o = oq.pop_front();
        chk("rnd_rsp", {instr_rvalid, instr_rdata, data_rvalid, data_rdata},
            {!o, (!o ? rd : 32'h0), o, (o ? rd : 32'h0)});
      end else begin
        chk("rnd_norsp", {instr_rvalid, instr_rdata, data_rvalid, data_rdata}, '0);
      end
      if (ip && !eig) wcnt = (wcnt < WM) ? wcnt + 1 : WM;
      else            wcnt = 0;
      if (eig || edg) begin
        oq.push_back(w);
        lk = 0;
        if (w) dp = 0; else ip = 0;
      end else if (mreq) begin
        lk = 1; lkw = w;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port memory between the core's instruction-fetch and data ports in the verilator test harness. It implements the core's req/gnt/rvalid handshake on both requester sides and on the memory side. Up to two accesses may be outstanding; responses are routed back in order through a 2-entry owner FIFO. Data has fixed priority, and an optional starvation guard bounds how long instruction fetch can wait.

## Interface
- ADDR_WIDTH, 22, byte-address width on all ports
- DATA_WIDTH, 32, read/write data width on all ports
- WAIT_MAX, 4, cycles a pending fetch may lose before it is forced to win (starvation guard only)
- clk_i  in  1  clock
- rst_i  in  1  reset: one clock; reset is asynchronous and active-high
- instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1  fetch handshake
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_rdata_o  out  DATA_WIDTH  fetch data
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1  load/store handshake
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  write enable
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_wdata_i  in  DATA_WIDTH  write data
- data_rdata_o  out  DATA_WIDTH  load data
- mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1  memory handshake
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data

## Operation
- Requests follow the handshake rules: req stays high with stable attributes until gnt; a transfer occurs on a cycle with req && gnt.
- Selection when unlocked: data wins if data_req_i, otherwise instr. With the starvation guard, instr wins when wait_cnt == WAIT_MAX.
- mem_req_o = (instr_req_i || data_req_i) && fifo not full. Memory-side attributes are driven from the selected port.
- For a fetch, mem_we_o = 0, mem_be_o = all ones and mem_wdata_o = 0.
- Lock: if mem_req_o && !mem_gnt_i, set sel_lock and hold the selection until mem_gnt_i; this keeps mem_addr_o stable across stalls.
- gnt to the selected port = mem_req_o && mem_gnt_i. The other port's gnt is 0.
- Owner FIFO: 2 entries of 1 bit (0 = instr, 1 = data).
  - Push the winner on each memory transfer.
  - Pop on mem_rvalid_i; the head routes mem_rvalid_i and mem_rdata_i.
  - A write still receives rvalid.
- Push and pop in the same cycle are legal, so a full FIFO popping can accept a push. This is evaluated with pop first (full && mem_rvalid_i counts as not full).
- Unselected rdata outputs are driven to 0.
- mem_rvalid_i while the FIFO is empty is a protocol error. It is ignored (no rvalid to either port) and flagged by an assertion.

## Timing
- Request path is combinational (req → mem_req_o → mem_gnt_i → gnt) with zero added latency.
- Response path is combinational (mem_rvalid_i → port rvalid), with no added latency.
- Back-to-back grants are allowed every cycle while the FIFO has space.
- Reset values:
  - all gnt/rvalid/mem_req_o are 0
  - FIFO is empty
  - sel_lock = 0
  - wait_cnt = 0
  - rdata outputs are 0
- Reset mid-transaction discards outstanding owners; later mem_rvalid_i pulses are ignored as described above.
- wait_cnt is a $clog2(WAIT_MAX+1)-bit counter.
  - Increments when instr_req_i && !instr_gnt_o, saturating at WAIT_MAX.
  - Clears on instr grant or when instr_req_i is low.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: wait_cnt is compiled in, and a fetch that has waited WAIT_MAX cycles wins the next arbitration over data.
- MEM_ARB_STARVE_GUARD_EN undefined: strict data-over-instr priority, no counter, and WAIT_MAX is unused.

## Test plan
- Single fetch to 0x80, memory gnt immediate, rvalid the next cycle with 0x00000013 → instr_gnt_o is high in the request cycle, instr_rvalid_o then goes high with instr_rdata_o = 0x00000013, and data_rvalid_o stays 0.
- Both requests in the same cycle (instr 0x100, data store 0x2000 with be = 0xF) → data is granted first and instr the next cycle; rvalids return in order data, then instr.
- mem_gnt_i held low 3 cycles while data_req_i rises mid-stall on top of a pending instr request → mem_addr_o stays at the instr address until the grant, then data follows.
- Two grants with no rvalid → FIFO full; mem_req_o is 0 the next cycle. Then a cycle with mem_rvalid_i plus a pending request → pop and push in the same cycle, so the grant is issued.
- With guard, WAIT_MAX = 4, data_req_i held high continuously and instr_req_i high → instr is granted on its 5th request cycle. Without the guard, instr is never granted.
- Assert rst_i for 1 cycle with 2 accesses outstanding → all outputs are 0; the following mem_rvalid_i produces no port rvalid.
